// File: rtl/mc_control_if.sv
// ============================================================================
// Module      : mc_control_if
// Description : Instruction-field, flag and handshake inputs plus datapath
//               control outputs of the multicycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd_field;
  logic [1:0] sh;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic       reg_write;
  logic [2:0] alu_control;
  logic [3:0] state;

  // Controller side
  modport master (
    input  cond, op, funct, rd_field, sh, alu_flags, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, reg_write, alu_control, state
  );

  // Datapath side
  modport slave (
    output cond, op, funct, rd_field, sh, alu_flags, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, reg_write, alu_control, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle ARM-subset main controller: state sequencing,
//               NZCV flags register and condition-code evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm #(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_orr = 3'b011;
  localparam logic [2:0] c_alu_mov = 3'b100;
  localparam logic [2:0] c_alu_lsl = 3'b101;
  localparam logic [2:0] c_alu_lsr = 3'b110;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_flags;
  logic [3:0] r_exec_flags;

  logic       w_ready, w_condex, w_nowrite, w_wb;
  logic       w_n, w_z, w_c, w_v;
  logic [3:0] w_cmd;
  logic [2:0] w_dp_alu;
  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_result_src, w_alu_src_b;
  logic [2:0] w_alu_control;

  assign w_ready   = ~MEM_WAIT_EN | bus.mem_ready;
  assign w_cmd     = bus.funct[4:1];
  assign w_nowrite = (w_cmd == 4'b1010);
  assign {w_n, w_z, w_c, w_v} = r_flags;

  // ALU flags are captured in the execute cycle and committed in ALUWB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_flags      <= 4'b0000;
      r_exec_flags <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXECR || r_state == S_EXECI)
        r_exec_flags <= bus.alu_flags;
      if (r_state == S_ALUWB && bus.funct[0] && w_condex)
        r_flags <= r_exec_flags;
    end
  end

  always_comb begin
    w_condex = 1'b0;
    case (bus.cond)
      4'h0:    w_condex = w_z;
      4'h1:    w_condex = ~w_z;
      4'h2:    w_condex = w_c;
      4'h3:    w_condex = ~w_c;
      4'h4:    w_condex = w_n;
      4'h5:    w_condex = ~w_n;
      4'h6:    w_condex = w_v;
      4'h7:    w_condex = ~w_v;
      4'h8:    w_condex = w_c & ~w_z;
      4'h9:    w_condex = ~w_c | w_z;
      4'hA:    w_condex = (w_n == w_v);
      4'hB:    w_condex = (w_n != w_v);
      4'hC:    w_condex = ~w_z & (w_n == w_v);
      4'hD:    w_condex = w_z | (w_n != w_v);
      4'hE:    w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  always_comb begin
    w_dp_alu = c_alu_add;
    case (w_cmd)
      4'b0100:         w_dp_alu = c_alu_add;
      4'b0010, 4'b1010: w_dp_alu = c_alu_sub;
      4'b0000:         w_dp_alu = c_alu_and;
      4'b1100:         w_dp_alu = c_alu_orr;
      4'b1101: begin
        case (bus.sh)
          2'b00:   w_dp_alu = c_alu_lsl;
          2'b01:   w_dp_alu = c_alu_lsr;
          default: w_dp_alu = c_alu_mov;
        endcase
      end
      default:         w_dp_alu = c_alu_add;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = c_alu_add;
    w_wb          = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        if (w_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        case (bus.op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = bus.funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_b = 2'b01;
        w_next      = bus.funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = w_condex;
        if (w_ready) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_wb         = w_condex;
        w_next       = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_b   = 2'b00;
        w_alu_control = w_dp_alu;
        w_next        = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_b   = 2'b01;
        w_alu_control = w_dp_alu;
        w_next        = S_ALUWB;
      end
      S_ALUWB: begin
        w_result_src = 2'b00;
        w_wb         = w_condex & ~w_nowrite;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = w_condex;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Writeback to R15 redirects into the PC instead of the register file
    if (w_wb) begin
      if (bus.rd_field == 4'hF) w_pc_write  = 1'b1;
      else                      w_reg_write = 1'b1;
    end
  end

  // Enables are gated by reset so nothing is written while it is held
  assign bus.pc_write    = w_pc_write  & rst_n;
  assign bus.mem_write   = w_mem_write & rst_n;
  assign bus.ir_write    = w_ir_write  & rst_n;
  assign bus.reg_write   = w_reg_write & rst_n;
  assign bus.adr_src     = w_adr_src;
  assign bus.result_src  = w_result_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_control = w_alu_control;
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {(bus.op == 2'b01) & ~bus.funct[0], (bus.op == 2'b10)};
  assign bus.state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Directed scoreboard bench for mc_control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mc_control_if bus ();
  mc_control_if bus_nw ();

  mc_control_fsm #(.MEM_WAIT_EN(1'b1)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
  mc_control_fsm #(.MEM_WAIT_EN(1'b0)) dut_nw (.clk(clk), .rst_n(rst_n), .bus(bus_nw));

  // Second instance sees the same instruction but a memory that never answers
  assign bus_nw.cond      = bus.cond;
  assign bus_nw.op        = bus.op;
  assign bus_nw.funct     = bus.funct;
  assign bus_nw.rd_field  = bus.rd_field;
  assign bus_nw.sh        = bus.sh;
  assign bus_nw.alu_flags = bus.alu_flags;
  assign bus_nw.mem_ready = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   nw_chk      = 1'b0;

  task automatic set_instr(input logic [31:0] ins);
    bus.cond     = ins[31:28];
    bus.op       = ins[27:26];
    bus.funct    = ins[25:20];
    bus.rd_field = ins[15:12];
    bus.sh       = ins[6:5];
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] st,
                      input logic irw, input logic pcw, input logic rw, input logic mw);
    exp_t e, o, onw;
    e.st = st; e.irw = irw; e.pcw = pcw; e.rw = rw; e.mw = mw;
    sb.push_back(e);
    @(negedge clk);
    o   = exp_t'({bus.state, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write});
    onw = exp_t'({bus_nw.state, bus_nw.ir_write, bus_nw.pc_write, bus_nw.reg_write, bus_nw.mem_write});
    e   = sb.pop_front();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed st=%0d ir=%b pc=%b rw=%b mw=%b expected st=%0d ir=%b pc=%b rw=%b mw=%b",
             tag, o.st, o.irw, o.pcw, o.rw, o.mw, e.st, e.irw, e.pcw, e.rw, e.mw);
    end
    if (nw_chk) begin
      vectors++;
      assert (onw === e) else begin
        miscompares++;
        $error("FAIL %s_nowait: observed st=%0d ir=%b pc=%b rw=%b mw=%b expected st=%0d ir=%b pc=%b rw=%b mw=%b",
               tag, onw.st, onw.irw, onw.pcw, onw.rw, onw.mw, e.st, e.irw, e.pcw, e.rw, e.mw);
      end
    end
  endtask

  task automatic stepa(input string tag, input logic [3:0] st,
                       input logic irw, input logic pcw, input logic rw, input logic mw);
    step(tag, st, irw, pcw, rw, mw);
    adv();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_ready = 1'b1;
    bus.alu_flags = 4'b0000;
    set_instr(32'hE2802005);
    repeat (2) @(posedge clk);
    // Reset held with memory ready: FETCH but no enables
    step("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    rst_n  = 1'b1;
    nw_chk = 1'b1;

    // ADD R2,R0,#5
    stepa("add_fetch",  4'd0, 1, 1, 0, 0);
    stepa("add_decode", 4'd1, 0, 0, 0, 0);
    step ("add_execi",  4'd7, 0, 0, 0, 0);
    chk("add_aluctl", {1'b0, bus.alu_control}, 4'h0);
    chk("add_srcb",   {2'b0, bus.alu_src_b},   4'h1);
    adv();
    stepa("add_aluwb",  4'd8, 0, 0, 1, 0);

    // LDR R1,[R0]
    set_instr(32'hE5901000);
    stepa("ldr_fetch",  4'd0, 1, 1, 0, 0);
    stepa("ldr_decode", 4'd1, 0, 0, 0, 0);
    stepa("ldr_memadr", 4'd2, 0, 0, 0, 0);
    step ("ldr_memrd",  4'd3, 0, 0, 0, 0);
    chk("ldr_adrsrc", {3'b0, bus.adr_src}, 4'h1);
    adv();
    step ("ldr_memwb",  4'd4, 0, 0, 1, 0);
    chk("ldr_ressrc", {2'b0, bus.result_src}, 4'h1);
    adv();

    // STR R3,[R0,#1]
    set_instr(32'hE5803001);
    stepa("str_fetch",  4'd0, 1, 1, 0, 0);
    stepa("str_decode", 4'd1, 0, 0, 0, 0);
    step ("str_memadr", 4'd2, 0, 0, 0, 0);
    chk("str_regsrc", {2'b0, bus.reg_src}, 4'h2);
    adv();
    stepa("str_memwr",  4'd5, 0, 0, 0, 1);

    // CMP R1,R2 producing Z
    set_instr(32'hE1510002);
    stepa("cmp_fetch",  4'd0, 1, 1, 0, 0);
    stepa("cmp_decode", 4'd1, 0, 0, 0, 0);
    bus.alu_flags = 4'b0100;
    step ("cmp_execr",  4'd6, 0, 0, 0, 0);
    chk("cmp_aluctl", {1'b0, bus.alu_control}, 4'h1);
    chk("cmp_srcb",   {2'b0, bus.alu_src_b},   4'h0);
    adv();
    bus.alu_flags = 4'b0000;
    stepa("cmp_aluwb",  4'd8, 0, 0, 0, 0);

    // ADDNE skipped, ADDEQ taken
    set_instr(32'h12802001);
    stepa("addne_fetch",  4'd0, 1, 1, 0, 0);
    stepa("addne_decode", 4'd1, 0, 0, 0, 0);
    stepa("addne_execi",  4'd7, 0, 0, 0, 0);
    stepa("addne_aluwb",  4'd8, 0, 0, 0, 0);
    set_instr(32'h02802001);
    stepa("addeq_fetch",  4'd0, 1, 1, 0, 0);
    stepa("addeq_decode", 4'd1, 0, 0, 0, 0);
    stepa("addeq_execi",  4'd7, 0, 0, 0, 0);
    stepa("addeq_aluwb",  4'd8, 0, 0, 1, 0);

    // ADD R15,R15,R0 writes the PC
    set_instr(32'hE08FF000);
    stepa("addpc_fetch",  4'd0, 1, 1, 0, 0);
    stepa("addpc_decode", 4'd1, 0, 0, 0, 0);
    stepa("addpc_execr",  4'd6, 0, 0, 0, 0);
    stepa("addpc_aluwb",  4'd8, 0, 1, 0, 0);

    // B always
    set_instr(32'hEA000001);
    stepa("b_fetch",  4'd0, 1, 1, 0, 0);
    stepa("b_decode", 4'd1, 0, 0, 0, 0);
    step ("b_branch", 4'd9, 0, 1, 0, 0);
    chk("b_ressrc", {2'b0, bus.result_src}, 4'h2);
    chk("b_regsrc", {2'b0, bus.reg_src},    4'h1);
    adv();

    // MOVS R1,R1,LSR clears flags
    set_instr(32'hE1B01021);
    stepa("movs_fetch",  4'd0, 1, 1, 0, 0);
    stepa("movs_decode", 4'd1, 0, 0, 0, 0);
    step ("movs_execr",  4'd6, 0, 0, 0, 0);
    chk("movs_aluctl", {1'b0, bus.alu_control}, 4'h6);
    adv();
    stepa("movs_aluwb",  4'd8, 0, 0, 1, 0);

    // BEQ with Z=0 not taken
    set_instr(32'h0A000001);
    stepa("beq_fetch",  4'd0, 1, 1, 0, 0);
    stepa("beq_decode", 4'd1, 0, 0, 0, 0);
    stepa("beq_branch", 4'd9, 0, 0, 0, 0);
    nw_chk = 1'b0;

    // Wait states on fetch, read and write
    set_instr(32'hE5901000);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) stepa("wldr_fetch_wait", 4'd0, 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    stepa("wldr_fetch",  4'd0, 1, 1, 0, 0);
    stepa("wldr_decode", 4'd1, 0, 0, 0, 0);
    stepa("wldr_memadr", 4'd2, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) stepa("wldr_memrd_wait", 4'd3, 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    stepa("wldr_memrd",  4'd3, 0, 0, 0, 0);
    stepa("wldr_memwb",  4'd4, 0, 0, 1, 0);
    set_instr(32'hE5803001);
    stepa("wstr_fetch",  4'd0, 1, 1, 0, 0);
    stepa("wstr_decode", 4'd1, 0, 0, 0, 0);
    stepa("wstr_memadr", 4'd2, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) stepa("wstr_memwr_wait", 4'd5, 0, 0, 0, 1);
    bus.mem_ready = 1'b1;
    stepa("wstr_memwr",  4'd5, 0, 0, 0, 1);

    // Set Z, then reset in the middle of a flag-setting ADDS
    set_instr(32'hE1510002);
    stepa("cmp2_fetch",  4'd0, 1, 1, 0, 0);
    stepa("cmp2_decode", 4'd1, 0, 0, 0, 0);
    bus.alu_flags = 4'b0100;
    stepa("cmp2_execr",  4'd6, 0, 0, 0, 0);
    bus.alu_flags = 4'b0000;
    stepa("cmp2_aluwb",  4'd8, 0, 0, 0, 0);
    set_instr(32'hE0912000);
    stepa("adds_fetch",  4'd0, 1, 1, 0, 0);
    stepa("adds_decode", 4'd1, 0, 0, 0, 0);
    bus.alu_flags = 4'b1111;
    step ("adds_execr",  4'd6, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", bus.state,                4'h0);
    chk("rst_async_en",    {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}, 4'h0);
    chk("rst_async_nw",    bus_nw.state,             4'h0);
    bus.alu_flags = 4'b0000;
    adv();
    chk("rst_hold_en",     {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}, 4'h0);
    rst_n  = 1'b1;
    nw_chk = 1'b1;

    // Flags cleared by reset: EQ fails, NE passes
    set_instr(32'h02802001);
    stepa("post_addeq_fetch",  4'd0, 1, 1, 0, 0);
    stepa("post_addeq_decode", 4'd1, 0, 0, 0, 0);
    stepa("post_addeq_execi",  4'd7, 0, 0, 0, 0);
    stepa("post_addeq_aluwb",  4'd8, 0, 0, 0, 0);
    set_instr(32'h12802001);
    stepa("post_addne_fetch",  4'd0, 1, 1, 0, 0);
    stepa("post_addne_decode", 4'd1, 0, 0, 0, 0);
    stepa("post_addne_execi",  4'd7, 0, 0, 0, 0);
    stepa("post_addne_aluwb",  4'd8, 0, 0, 1, 0);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
